// File: rtl/mod_cond_sub_if.sv
// Request/response bundle for mod_cond_sub; ge_flag exists only when MOD_CS_FLAG_EN is defined.
interface mod_cond_sub_if #(
   parameter int unsigned WIDTH = 434
);
   logic             start;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] p;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
`ifdef MOD_CS_FLAG_EN
   logic             ge_flag;

   modport master (output start, x, p, input busy, done, result, ge_flag);
   modport slave  (input start, x, p, output busy, done, result, ge_flag);
`else
   modport master (output start, x, p, input busy, done, result);
   modport slave  (input start, x, p, output busy, done, result);
`endif
endinterface

// File: rtl/mod_cond_sub.sv
// Digit-serial conditional subtractor: result = (x >= p) ? x - p : x, one DIGIT-bit limb per cycle.
// Define MOD_CS_FLAG_EN to add the registered ge_flag output (x >= p of the last operation).
module mod_cond_sub #(
   parameter int unsigned WIDTH = 434,
   parameter int unsigned DIGIT = 64
) (
   input logic           clk,
   input logic           rst,
   mod_cond_sub_if.slave bus
);
   localparam int unsigned NDIG  = (WIDTH + DIGIT - 1) / DIGIT;
   localparam int unsigned PW    = NDIG * DIGIT;
   localparam int unsigned LOW_W = (NDIG - 1) * DIGIT;
   localparam int unsigned TOP_W = WIDTH - LOW_W;
   localparam int unsigned IW    = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic [1:0] {StIdle, StSub, StDone} state_e;

   state_e           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             borrow_q, borrow_d;
   logic [PW-1:0]    x_sh_q, x_sh_d;
   logic [PW-1:0]    p_sh_q, p_sh_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [LOW_W-1:0] lo_q, lo_d;
   logic [TOP_W-1:0] top_q, top_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
`ifdef MOD_CS_FLAG_EN
   logic             ge_q, ge_d;
`endif

   // One limb of the shared borrow chain; bit DIGIT is the borrow out.
   logic [DIGIT:0]   sub_w;
   logic [LOW_W-1:0] lo_shift;

   assign sub_w = {1'b0, x_sh_q[DIGIT-1:0]} - {1'b0, p_sh_q[DIGIT-1:0]}
                  - {{DIGIT{1'b0}}, borrow_q};

   // Full limbs shift in from the top; the padded top limb is kept separately so pad bits
   // are never stored.
   if (LOW_W > DIGIT) begin : g_lo_wide
      assign lo_shift = {sub_w[DIGIT-1:0], lo_q[LOW_W-1:DIGIT]};
   end else begin : g_lo_one
      assign lo_shift = sub_w[DIGIT-1:0];
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      borrow_d = borrow_q;
      x_sh_d   = x_sh_q;
      p_sh_d   = p_sh_q;
      x_d      = x_q;
      lo_d     = lo_q;
      top_d    = top_q;
      result_d = result_q;
      busy_d   = 1'b1;
      done_d   = 1'b0;
`ifdef MOD_CS_FLAG_EN
      ge_d     = ge_q;
`endif
      unique case (state_q)
         StIdle: begin
            busy_d = bus.start;
            if (bus.start) begin
               x_sh_d   = PW'(bus.x);
               p_sh_d   = PW'(bus.p);
               x_d      = bus.x;
               idx_d    = '0;
               borrow_d = 1'b0;
               state_d  = StSub;
            end
         end
         StSub: begin
            x_sh_d   = x_sh_q >> DIGIT;
            p_sh_d   = p_sh_q >> DIGIT;
            borrow_d = sub_w[DIGIT];
            idx_d    = idx_q + 1'b1;
            if (idx_q == IW'(NDIG - 1)) begin
               top_d   = sub_w[TOP_W-1:0];
               state_d = StDone;
            end else begin
               lo_d = lo_shift;
            end
         end
         StDone: begin
            done_d   = 1'b1;
            result_d = borrow_q ? x_q : {top_q, lo_q};
`ifdef MOD_CS_FLAG_EN
            ge_d     = ~borrow_q;
`endif
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         borrow_q <= 1'b0;
         x_sh_q   <= '0;
         p_sh_q   <= '0;
         x_q      <= '0;
         lo_q     <= '0;
         top_q    <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef MOD_CS_FLAG_EN
         ge_q     <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         borrow_q <= borrow_d;
         x_sh_q   <= x_sh_d;
         p_sh_q   <= p_sh_d;
         x_q      <= x_d;
         lo_q     <= lo_d;
         top_q    <= top_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef MOD_CS_FLAG_EN
         ge_q     <= ge_d;
`endif
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
`ifdef MOD_CS_FLAG_EN
   assign bus.ge_flag = ge_q;
`endif

endmodule

// File: tb/tb_mod_cond_sub.sv
// Bench for mod_cond_sub: 16/4 instance for directed corner cases, 434/64 instance against p434.
module tb_mod_cond_sub;
   localparam int W      = 434;
   localparam int NDIG_S = 4;
   localparam int NDIG_L = 7;
   localparam int NRAND  = 3000;
   localparam logic [W-1:0] P434 =
      {218'h2341F271773446CFC5FD681C520567BC65C783158AEA3FDC1767AE2, {216{1'b1}}};

   typedef struct {
      logic [15:0] x;
      logic [15:0] p;
      logic [15:0] res;
      logic        ge;
   } vec_t;

   typedef struct {
      logic [W-1:0] res;
      logic         ge;
      int           t0;
   } sb_t;

   logic clk = 1'b0;
   logic rst_s, rst_l;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   sb_t  sq_s[$];
   sb_t  sq_l[$];

   mod_cond_sub_if #(.WIDTH(16)) bif_s ();
   mod_cond_sub_if #(.WIDTH(W))  bif_l ();

   mod_cond_sub #(.WIDTH(16), .DIGIT(4)) dut_s (.clk(clk), .rst(rst_s), .bus(bif_s));
   mod_cond_sub #(.WIDTH(W), .DIGIT(64)) dut_l (.clk(clk), .rst(rst_l), .bus(bif_l));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin : mon_s
      sb_t e;
      if (bif_s.done === 1'b1) begin
         if (sq_s.size() == 0) begin
            check("s_unexpected_done", W'(bif_s.done), W'(1'b0));
         end else begin
            e = sq_s.pop_front();
            check("s_result", W'(bif_s.result), e.res);
            check("s_latency", W'(cyc - e.t0), W'(NDIG_S + 1));
            check("s_busy_in_done", W'(bif_s.busy), W'(1'b1));
`ifdef MOD_CS_FLAG_EN
            check("s_ge_flag", W'(bif_s.ge_flag), W'(e.ge));
`endif
         end
      end
   end

   always @(negedge clk) begin : mon_l
      sb_t e;
      if (bif_l.done === 1'b1) begin
         if (sq_l.size() == 0) begin
            check("l_unexpected_done", W'(bif_l.done), W'(1'b0));
         end else begin
            e = sq_l.pop_front();
            check("l_result", bif_l.result, e.res);
            check("l_latency", W'(cyc - e.t0), W'(NDIG_L + 1));
`ifdef MOD_CS_FLAG_EN
            check("l_ge_flag", W'(bif_l.ge_flag), W'(e.ge));
`endif
         end
      end
   end

   task automatic run_s(input logic [15:0] xv, input logic [15:0] pv, input logic [15:0] rv,
                        input logic gv);
      sb_t e;
      @(negedge clk);
      bif_s.start = 1'b1;
      bif_s.x     = xv;
      bif_s.p     = pv;
      e.res = W'(rv);
      e.ge  = gv;
      e.t0  = cyc + 1;
      sq_s.push_back(e);
      @(negedge clk);
      bif_s.start = 1'b0;
      bif_s.x     = 16'($urandom);
      bif_s.p     = 16'($urandom);
      check("s_busy_after_start", W'(bif_s.busy), W'(1'b1));
   endtask

   task automatic wait_idle_s();
      int n = 0;
      while (bif_s.busy !== 1'b0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("s_idle_reached", W'(bif_s.busy), W'(1'b0));
   endtask

   task automatic wait_idle_l();
      int n = 0;
      while (bif_l.busy !== 1'b0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("l_idle_reached", W'(bif_l.busy), W'(1'b0));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      vec_t         vecs[7];
      sb_t          e;
      logic [447:0] r;
      logic [W-1:0] xv;
      int           t0;

      rst_s = 1'b1;
      rst_l = 1'b1;
      bif_s.start = 1'b0;
      bif_s.x     = '0;
      bif_s.p     = '0;
      bif_l.start = 1'b0;
      bif_l.x     = '0;
      bif_l.p     = '0;
      repeat (3) @(negedge clk);
      rst_s = 1'b0;
      rst_l = 1'b0;

      check("s_reset_busy", W'(bif_s.busy), W'(1'b0));
      check("s_reset_done", W'(bif_s.done), W'(1'b0));
      check("s_reset_result", W'(bif_s.result), '0);
      check("l_reset_busy", W'(bif_l.busy), W'(1'b0));
      check("l_reset_result", bif_l.result, '0);
`ifdef MOD_CS_FLAG_EN
      check("s_reset_ge", W'(bif_s.ge_flag), W'(1'b0));
`endif

      vecs[0] = '{x: 16'h8001, p: 16'h8001, res: 16'h0000, ge: 1'b1};
      vecs[1] = '{x: 16'h8000, p: 16'h8001, res: 16'h8000, ge: 1'b0};
      vecs[2] = '{x: 16'hFFFF, p: 16'h8001, res: 16'h7FFE, ge: 1'b1};
      vecs[3] = '{x: 16'h1234, p: 16'h1000, res: 16'h0234, ge: 1'b1};
      vecs[4] = '{x: 16'h0005, p: 16'h0007, res: 16'h0005, ge: 1'b0};
      vecs[5] = '{x: 16'h0E00, p: 16'h0700, res: 16'h0700, ge: 1'b1};
      vecs[6] = '{x: 16'h0000, p: 16'h8001, res: 16'h0000, ge: 1'b0};
      for (int i = 0; i < 7; i++) begin
         run_s(vecs[i].x, vecs[i].p, vecs[i].res, vecs[i].ge);
         wait_idle_s();
      end

      // Result must hold while the operand inputs wander.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         bif_s.x = 16'($urandom);
         bif_s.p = 16'($urandom);
         check("s_hold_result", W'(bif_s.result), '0);
         check("s_hold_no_done", W'(bif_s.done), W'(1'b0));
      end

      // start pulsed mid-operation is ignored.
      run_s(16'h1234, 16'h8001, 16'h1234, 1'b0);
      @(negedge clk);
      bif_s.start = 1'b1;
      bif_s.x     = 16'hFFFF;
      @(negedge clk);
      bif_s.start = 1'b0;
      wait_idle_s();
      repeat (8) @(negedge clk);
      check("s_repulse_result", W'(bif_s.result), W'(16'h1234));

      // Reset sampled at t+3 aborts the operation without a done pulse.
      run_s(16'hFFFF, 16'h8001, 16'h7FFE, 1'b1);
      @(negedge clk);
      @(negedge clk);
      rst_s = 1'b1;
      @(negedge clk);
      rst_s = 1'b0;
      sq_s.delete();
      check("s_abort_busy", W'(bif_s.busy), W'(1'b0));
      check("s_abort_done", W'(bif_s.done), W'(1'b0));
      check("s_abort_result", W'(bif_s.result), '0);
`ifdef MOD_CS_FLAG_EN
      check("s_abort_ge", W'(bif_s.ge_flag), W'(1'b0));
`endif
      repeat (10) @(negedge clk);
      check("s_abort_idle", W'(bif_s.busy), W'(1'b0));
      run_s(16'h9000, 16'h8001, 16'h0FFF, 1'b1);
      wait_idle_s();

      // start held high: accepts every NDIG+2 cycles.
      @(negedge clk);
      bif_s.start = 1'b1;
      bif_s.x     = 16'hC000;
      bif_s.p     = 16'h8001;
      t0 = cyc + 1;
      for (int k = 0; k < 3; k++) begin
         e.res = W'(16'h3FFF);
         e.ge  = 1'b1;
         e.t0  = t0 + k * (NDIG_S + 2);
         sq_s.push_back(e);
      end
      repeat (13) @(negedge clk);
      bif_s.start = 1'b0;
      wait_idle_s();
      check("s_sb_drained", W'(sq_s.size()), '0);

      // Wide instance against p434.
      for (int i = 0; i < NRAND; i++) begin
         r  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         xv = r[W-1:0];
         case (i)
            0: xv = '0;
            1: xv = P434;
            2: xv = P434 - 1'b1;
            3: xv = P434 + 1'b1;
            4: xv = {W{1'b1}};
            default: ;
         endcase
         @(negedge clk);
         bif_l.start = 1'b1;
         bif_l.x     = xv;
         bif_l.p     = P434;
         e.res = (xv >= P434) ? xv - P434 : xv;
         e.ge  = (xv >= P434);
         e.t0  = cyc + 1;
         sq_l.push_back(e);
         @(negedge clk);
         bif_l.start = 1'b0;
         bif_l.x     = ~xv;
         wait_idle_l();
      end
      repeat (2) @(negedge clk);
      check("l_sb_drained", W'(sq_l.size()), '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
